// File: rtl/filtro_pkg.sv
// Shared constants and types for the filtered-sample DAC serial transmitter.
package filtro_pkg;

    localparam int unsigned NF        = 25;
    localparam int unsigned MagnitudF = 8;
    localparam int unsigned DecimalF  = 16;

    localparam int unsigned FRAME_W = 16;
    localparam int unsigned DAC_W   = 12;
    localparam int unsigned CTRL_W  = FRAME_W - DAC_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // DAC frame: zero control nibble followed by the offset-binary code
    function automatic logic [FRAME_W-1:0] build_frame(input logic [DAC_W-1:0] code);
        return {{CTRL_W{1'b0}}, code};
    endfunction

endpackage

// File: rtl/dac_serial_tx_if.sv
// Sample-in / serial-out signal bundle of the DAC transmitter.
interface dac_serial_tx_if #(
    parameter int unsigned NF = filtro_pkg::NF
);
    logic          enable;
    logic [NF-1:0] Data_In;
    logic          sync_n;
    logic          sclk;
    logic          sdata;
    logic          busy;
    logic          done_tick;
    logic          overrun;

    modport master (
        output enable,
        output Data_In,
        input  sync_n,
        input  sclk,
        input  sdata,
        input  busy,
        input  done_tick,
        input  overrun
    );

    modport slave (
        input  enable,
        input  Data_In,
        output sync_n,
        output sclk,
        output sdata,
        output busy,
        output done_tick,
        output overrun
    );
endinterface

// File: rtl/generador_sclk.sv
// Divider producing alternating fall/rise ticks every DIV cycles (DIV >= 2).
module generador_sclk #(
    parameter int unsigned DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    output logic o_fall_c,
    output logic o_rise_c
);
    localparam int unsigned CNT_W = $clog2(DIV);

    logic [CNT_W-1:0] r_cnt;
    logic             r_phase;
    logic             w_tick;

    // A tick closes each DIV-cycle window; the first one after a clear is a fall
    assign w_tick   = (r_cnt == CNT_W'(DIV - 1)) && !i_clear;
    assign o_fall_c = w_tick && !r_phase;
    assign o_rise_c = w_tick &&  r_phase;

    // Window counter and phase (0: next tick is a fall, 1: next tick is a rise)
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (i_clear) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (w_tick) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/dac_serial_tx.sv
// Converts fixed-point samples to 12-bit offset binary and shifts 16-bit frames to a serial DAC.
module dac_serial_tx #(
    parameter int unsigned NF        = filtro_pkg::NF,
    parameter int unsigned MagnitudF = filtro_pkg::MagnitudF,
    parameter int unsigned DecimalF  = filtro_pkg::DecimalF,
    parameter int unsigned DIV       = 4
) (
    input  logic           clock_In,
    input  logic           Reset,
    dac_serial_tx_if.slave bus
);
    import filtro_pkg::*;

    localparam int unsigned INT_W  = MagnitudF + 1;
    localparam int unsigned FCNT_W = $clog2(FRAME_W) + 1;

    state_t              r_state, w_state_nxt;
    logic [FRAME_W-1:0]  r_shift, w_shift_nxt;
    logic                r_sclk, w_sclk_nxt;
    logic                r_sync_n, w_sync_n_nxt;
    logic [FCNT_W-1:0]   r_fall_cnt, w_fall_cnt_nxt;
    logic                r_hold_vld, w_hold_vld_nxt;
    logic [DAC_W-1:0]    r_hold_code, w_hold_code_nxt;
    logic                r_done, w_done_nxt;
    logic                r_overrun, w_overrun_nxt;
    logic                r_busy;

    logic                w_fall;
    logic                w_rise;
    logic                w_load;
    logic [DAC_W-1:0]    w_load_code;
    logic [DAC_W-1:0]    w_in_code;
    logic                w_drain;
    logic                w_direct;

    // Saturate to the 12-bit two's complement range, then flip the MSB to offset binary
    function automatic logic [DAC_W-1:0] to_code(input logic [NF-1:0] d);
        logic [INT_W-1:0] int_part;
        logic [DAC_W-1:0] tc;
        int_part = d[DecimalF +: INT_W];
        if ((&int_part) || !(|int_part)) begin
            tc = d[DecimalF -: DAC_W];
        end else if (d[NF-1]) begin
            tc = {1'b1, {(DAC_W-1){1'b0}}};
        end else begin
            tc = {1'b0, {(DAC_W-1){1'b1}}};
        end
        return {~tc[DAC_W-1], tc[DAC_W-2:0]};
    endfunction

    assign w_in_code = to_code(bus.Data_In);

    // The divider idles while IDLE; in GAP its fall/rise pair times the 2*DIV inter-frame gap
    generador_sclk #(
        .DIV (DIV)
    ) u_sclk (
        .i_clk    (clock_In),
        .i_rst    (Reset),
        .i_clear  (r_state == IDLE),
        .o_fall_c (w_fall),
        .o_rise_c (w_rise)
    );

    // An enable goes straight to the shifter only when idle with nothing pending
    assign w_direct = (r_state == IDLE) && !r_hold_vld;

    // Next-state, frame sequencing and holding-register control
    always_comb begin
        w_state_nxt     = r_state;
        w_shift_nxt     = r_shift;
        w_sclk_nxt      = r_sclk;
        w_sync_n_nxt    = r_sync_n;
        w_fall_cnt_nxt  = r_fall_cnt;
        w_hold_vld_nxt  = r_hold_vld;
        w_hold_code_nxt = r_hold_code;
        w_done_nxt      = 1'b0;
        w_overrun_nxt   = 1'b0;
        w_load          = 1'b0;
        w_load_code     = w_in_code;
        w_drain         = 1'b0;

        case (r_state)
            IDLE: begin
                if (r_hold_vld) begin
                    w_load      = 1'b1;
                    w_load_code = r_hold_code;
                    w_drain     = 1'b1;
                end else if (bus.enable) begin
                    w_load      = 1'b1;
                end
            end
            SHIFT: begin
                if (w_fall) begin
                    w_sclk_nxt     = 1'b0;
                    w_fall_cnt_nxt = r_fall_cnt + FCNT_W'(1);
                end else if (w_rise) begin
                    w_sclk_nxt = 1'b1;
                    if (r_fall_cnt == FCNT_W'(FRAME_W)) begin
                        w_sync_n_nxt   = 1'b1;
                        w_shift_nxt    = '0;
                        w_fall_cnt_nxt = '0;
                        w_state_nxt    = GAP;
                    end else begin
                        w_shift_nxt = {r_shift[FRAME_W-2:0], 1'b0};
                    end
                end
            end
            GAP: begin
                if (w_rise) begin
                    w_done_nxt = 1'b1;
                    if (r_hold_vld) begin
                        w_load      = 1'b1;
                        w_load_code = r_hold_code;
                        w_drain     = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_load) begin
            w_shift_nxt    = build_frame(w_load_code);
            w_sync_n_nxt   = 1'b0;
            w_sclk_nxt     = 1'b1;
            w_fall_cnt_nxt = '0;
            w_state_nxt    = SHIFT;
        end

        if (bus.enable && !w_direct) begin
            w_hold_vld_nxt  = 1'b1;
            w_hold_code_nxt = w_in_code;
            w_overrun_nxt   = r_hold_vld && !w_drain;
        end else if (w_drain) begin
            w_hold_vld_nxt  = 1'b0;
        end
    end

    // State and output registers; reset aborts any frame in flight
    always_ff @(posedge clock_In or posedge Reset) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_sclk      <= 1'b1;
            r_sync_n    <= 1'b1;
            r_fall_cnt  <= '0;
            r_hold_vld  <= 1'b0;
            r_hold_code <= '0;
            r_done      <= 1'b0;
            r_overrun   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_sclk      <= w_sclk_nxt;
            r_sync_n    <= w_sync_n_nxt;
            r_fall_cnt  <= w_fall_cnt_nxt;
            r_hold_vld  <= w_hold_vld_nxt;
            r_hold_code <= w_hold_code_nxt;
            r_done      <= w_done_nxt;
            r_overrun   <= w_overrun_nxt;
            r_busy      <= (w_state_nxt != IDLE);
        end
    end

    assign bus.sync_n    = r_sync_n;
    assign bus.sclk      = r_sclk;
    assign bus.sdata     = r_shift[FRAME_W-1];
    assign bus.busy      = r_busy;
    assign bus.done_tick = r_done;
    assign bus.overrun   = r_overrun;
endmodule

// File: tb/tb_dac_serial_tx.sv
// Self-checking bench for dac_serial_tx: vector table, timing corners and random samples.
module tb_dac_serial_tx;
    localparam int unsigned NF  = 25;
    localparam int unsigned DIV = 4;

    typedef struct {
        logic [NF-1:0] data;
        logic [15:0]   frame;
    } vec_t;

    logic clock_In = 1'b0;
    logic Reset;

    dac_serial_tx_if #(.NF(NF)) bus ();

    dac_serial_tx #(
        .NF        (NF),
        .MagnitudF (8),
        .DecimalF  (16),
        .DIV       (DIV)
    ) dut (
        .clock_In (clock_In),
        .Reset    (Reset),
        .bus      (bus)
    );

    always #5 clock_In = ~clock_In;

    int n_checks = 0;
    int n_errors = 0;

    // Line monitor state
    logic [15:0] cap = '0;
    int          nbits = 0;
    int          high_cnt = 1000;
    logic        prev_sclk = 1'b1;
    logic        prev_sync_n = 1'b1;
    logic        prev_sdata = 1'b0;
    logic [15:0] got_q[$];
    int          got_n[$];
    int          gap_q[$];
    int          done_cnt = 0;
    int          ovr_cnt = 0;
    int          idle_err = 0;
    int          hold_err = 0;

    // Decode the serial lines like the DAC: shift sdata on sclk falling edges while sync_n is low
    always @(negedge clock_In) begin
        if (Reset) begin
            cap   = '0;
            nbits = 0;
        end else begin
            if (prev_sclk && !bus.sclk) begin
                if (bus.sdata !== prev_sdata) hold_err++;
                if (!bus.sync_n) begin
                    cap = {cap[14:0], bus.sdata};
                    nbits++;
                end
            end
            if (!prev_sync_n && bus.sync_n) begin
                got_q.push_back(cap);
                got_n.push_back(nbits);
                cap      = '0;
                nbits    = 0;
                high_cnt = 0;
            end
            if (prev_sync_n && !bus.sync_n) gap_q.push_back(high_cnt);
            if (bus.sync_n) high_cnt++;
            if (bus.sync_n && (bus.sdata !== 1'b0 || bus.sclk !== 1'b1)) idle_err++;
            if (bus.done_tick === 1'b1) done_cnt++;
            if (bus.overrun === 1'b1) ovr_cnt++;
        end
        prev_sclk   = bus.sclk;
        prev_sync_n = bus.sync_n;
        prev_sdata  = bus.sdata;
    end

    // Reference: value/32 floored, clamped to [-2048, 2047], offset by 2048
    function automatic logic [15:0] model_frame(input logic [NF-1:0] d);
        longint v;
        longint q;
        v = longint'(d);
        if (d[NF-1]) v = v - (longint'(1) << NF);
        q = v >>> 5;
        if (q > 2047) q = 2047;
        if (q < -2048) q = -2048;
        return 16'(q + 2048);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clock_In);
        #1;
    endtask

    task automatic send(input logic [NF-1:0] d);
        bus.Data_In = d;
        bus.enable  = 1'b1;
        @(posedge clock_In);
        #1;
        bus.enable  = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((bus.busy !== 1'b0 || bus.sync_n !== 1'b1) && n < budget) begin
            @(posedge clock_In);
            #1;
            n++;
        end
        if (bus.busy !== 1'b0 || bus.sync_n !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: still busy after %0d cycles, required idle", name, budget);
        end
        cycles(1);
    endtask

    task automatic check_frame(input string name, input logic [15:0] exp);
        logic [15:0] f;
        int          nb;
        if (got_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: no frame captured, expected 0x%04h", name, exp);
        end else begin
            f  = got_q.pop_front();
            nb = got_n.pop_front();
            check({name, "_bits"}, 32'(nb), 32'd16);
            check(name, 32'(f), 32'(exp));
        end
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs[8];
        int          n, fall_n, rise_n, dc, ov0, edges, nq;
        logic        prev;
        logic [NF-1:0] a, b, c, d;

        vecs[0] = '{25'h0000000, 16'h0800};
        vecs[1] = '{25'h0008000, 16'h0C00};
        vecs[2] = '{25'h0010000, 16'h0FFF};
        vecs[3] = '{25'h1FF0000, 16'h0000};
        vecs[4] = '{25'h1F00000, 16'h0000};
        vecs[5] = '{25'h000FFFF, 16'h0FFF};
        vecs[6] = '{25'h1FFFFFF, 16'h07FF};
        vecs[7] = '{25'h0000020, 16'h0801};

        Reset       = 1'b1;
        bus.enable  = 1'b0;
        bus.Data_In = '0;
        cycles(3);
        check("rst_sync_n",    32'(bus.sync_n),    32'd1);
        check("rst_sclk",      32'(bus.sclk),      32'd1);
        check("rst_sdata",     32'(bus.sdata),     32'd0);
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_done_tick", 32'(bus.done_tick), 32'd0);
        check("rst_overrun",   32'(bus.overrun),   32'd0);
        Reset = 1'b0;
        cycles(2);

        // First frame: latency, first sclk fall, sync_n rise and done_tick timing
        send(25'h0000000);
        check("start_sync_n", 32'(bus.sync_n), 32'd0);
        check("start_sclk",   32'(bus.sclk),   32'd1);
        check("start_busy",   32'(bus.busy),   32'd1);
        n = 1; fall_n = 0; rise_n = 0;
        while (bus.done_tick !== 1'b1 && n < 40 * DIV) begin
            @(posedge clock_In);
            #1;
            n++;
            if (bus.sclk === 1'b0 && fall_n == 0) fall_n = n;
            if (bus.sync_n === 1'b1 && rise_n == 0) rise_n = n;
        end
        check("first_sclk_fall", 32'(fall_n), 32'(DIV + 1));
        check("sync_n_rise",     32'(rise_n), 32'(32 * DIV + 1));
        check("done_latency",    32'(n),      32'(34 * DIV + 1));
        cycles(1);
        check("done_width",      32'(bus.done_tick), 32'd0);
        check("idle_busy",       32'(bus.busy),      32'd0);
        check_frame("frame_zero", 16'h0800);

        // Conversion table
        for (int i = 0; i < 8; i++) begin
            dc = done_cnt;
            send(vecs[i].data);
            wait_idle($sformatf("vec%0d_idle", i), 60 * DIV);
            check_frame($sformatf("vec%0d", i), vecs[i].frame);
            check($sformatf("vec%0d_done", i), 32'(done_cnt - dc), 32'd1);
        end

        // A then B and C during A: C overwrites B, frames A and C only
        a = 25'h0004000; b = 25'h1FFC000; c = 25'h0002000;
        ov0 = ovr_cnt;
        gap_q.delete();
        send(a);
        cycles(10);
        send(b);
        check("ovr_on_b", 32'(bus.overrun), 32'd0);
        cycles(10);
        send(c);
        check("ovr_on_c", 32'(bus.overrun), 32'd1);
        cycles(1);
        check("ovr_width", 32'(bus.overrun), 32'd0);
        wait_idle("ovr_idle", 100 * DIV);
        check_frame("ovr_frame_a", model_frame(a));
        check_frame("ovr_frame_c", model_frame(c));
        check("ovr_b_not_sent", 32'(got_q.size()), 32'd0);
        check("ovr_count", 32'(ovr_cnt - ov0), 32'd1);
        check("ovr_frame_starts", 32'(gap_q.size()), 32'd2);
        if (gap_q.size() == 2) check("ovr_gap", 32'(gap_q[1]), 32'(2 * DIV));

        // Reset at the 7th sclk edge aborts the frame
        dc = done_cnt;
        nq = got_q.size();
        send(25'h0006000);
        n = 0; edges = 0; prev = bus.sclk;
        while (edges < 7 && n < 20 * DIV) begin
            @(posedge clock_In);
            #1;
            n++;
            if (bus.sclk !== prev) edges++;
            prev = bus.sclk;
        end
        check("rst_mid_edges", 32'(edges), 32'd7);
        Reset = 1'b1;
        #1;
        check("rst_mid_sync_n", 32'(bus.sync_n), 32'd1);
        check("rst_mid_sclk",   32'(bus.sclk),   32'd1);
        check("rst_mid_busy",   32'(bus.busy),   32'd0);
        check("rst_mid_sdata",  32'(bus.sdata),  32'd0);
        cycles(2);
        Reset = 1'b0;
        cycles(40 * DIV);
        check("rst_no_done",  32'(done_cnt - dc),  32'd0);
        check("rst_no_frame", 32'(got_q.size()),   32'(nq));
        d = 25'h1FFE000;
        send(d);
        wait_idle("rst_next_idle", 60 * DIV);
        check_frame("rst_next_frame", model_frame(d));
        check("rst_next_done", 32'(done_cnt - dc), 32'd1);

        // New enable on the same edge the pending sample drains: A, B, C in order, no overrun
        a = 25'h0001000; b = 25'h0003000; c = 25'h1FFD000;
        ov0 = ovr_cnt;
        gap_q.delete();
        send(a);
        cycles(5);
        send(b);
        cycles(34 * DIV - 1 - 6);
        check("drain_pre_sync_n", 32'(bus.sync_n), 32'd1);
        send(c);
        check("drain_overrun", 32'(bus.overrun), 32'd0);
        check("drain_sync_n",  32'(bus.sync_n),  32'd0);
        wait_idle("drain_idle", 150 * DIV);
        check_frame("drain_frame_a", model_frame(a));
        check_frame("drain_frame_b", model_frame(b));
        check_frame("drain_frame_c", model_frame(c));
        check("drain_ovr_count", 32'(ovr_cnt - ov0), 32'd0);
        check("drain_frame_starts", 32'(gap_q.size()), 32'd3);
        if (gap_q.size() == 3) begin
            check("drain_gap_b", 32'(gap_q[1]), 32'(2 * DIV));
            check("drain_gap_c", 32'(gap_q[2]), 32'(2 * DIV));
        end

        // Random samples against the reference model
        ov0 = ovr_cnt;
        for (int i = 0; i < 20; i++) begin
            case ($urandom_range(0, 2))
                0:       d = NF'(32'($urandom_range(0, 131071))) - NF'(65536);
                1:       d = NF'($urandom);
                default: d = NF'(32'($urandom_range(0, 63))) + NF'(65536 - 32);
            endcase
            cycles(int'($urandom_range(0, 3)));
            send(d);
            wait_idle($sformatf("rnd%0d_idle", i), 60 * DIV);
            check_frame($sformatf("rnd%0d", i), model_frame(d));
        end
        check("rnd_no_overrun", 32'(ovr_cnt - ov0), 32'd0);
        check("sdata_hold_on_fall", 32'(hold_err), 32'd0);
        check("idle_lines", 32'(idle_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/dac_serial_tx.md
DAC_SERIAL_TX -- requirements
Module: dac_serial_tx

Interface
REQ-001 The module SHALL have parameter NF, default 25, meaning sample word width (two's complement, sign bit plus MagnitudF plus DecimalF).
REQ-002 The module SHALL have parameter MagnitudF, default 8, meaning integer bits of Data_In.
REQ-003 The module SHALL have parameter DecimalF, default 16, meaning fraction bits of Data_In.
REQ-004 The module SHALL have parameter DIV, default 4, meaning clock_In cycles per sclk half-period (min 2).
REQ-005 The module SHALL have port clock_In, input, 1, the single system clock; all logic is on its rising edge.
REQ-006 The module SHALL have port Reset, input, 1, asynchronous and active-high.
REQ-007 The module SHALL have port enable, input, 1, a one-cycle sample strobe qualifying Data_In.
REQ-008 The module SHALL have port Data_In, input, NF, the filtered sample in fixed point.
REQ-009 The module SHALL have port sync_n, output, 1, the DAC frame select, active-low.
REQ-010 The module SHALL have port sclk, output, 1, the serial clock, idle high.
REQ-011 The module SHALL have port sdata, output, 1, serial data, MSB first.
REQ-012 The module SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-013 The module SHALL have port done_tick, output, 1, a one-cycle pulse at the end of each frame.
REQ-014 The module SHALL have port overrun, output, 1, a one-cycle pulse when a pending sample is overwritten.

Function
REQ-015 Conversion SHALL saturate: if Data_In[NF-1:DecimalF] are not all equal, clamp to 0x7FF (sign 0) or 0x800 (sign 1); otherwise code = Data_In[DecimalF:DecimalF-11]; then invert MSB to form 12-bit offset binary.
REQ-016 The frame SHALL be 16 bits: 4 zero control bits then the 12-bit code, MSB first.
REQ-017 The FSM SHALL have states IDLE, SHIFT and GAP.
REQ-018 In IDLE, enable=1 SHALL convert Data_In into the shift register, and the FSM SHALL enter SHIFT next cycle with sync_n=0 (latency 1 cycle).
REQ-019 In SHIFT, sclk SHALL toggle every DIV cycles, starting with a falling edge DIV cycles after sync_n falls; sdata SHALL change only on sclk rising edges and hold across each falling edge.
REQ-020 After the 16th sclk falling edge plus DIV cycles, with sclk high, sync_n SHALL rise and the FSM SHALL enter GAP.
REQ-021 GAP SHALL last 2*DIV cycles, then assert done_tick for one cycle and go to IDLE, or go directly to SHIFT if a sample is pending.
REQ-022 A one-entry holding register SHALL capture enable samples arriving while busy; a second arrival before it drains SHALL overwrite it (newest wins) and pulse overrun.
REQ-023 Simultaneous drain of the pending sample and a new enable SHALL load the new sample into the holding register with no overrun.
REQ-024 When idle, sdata SHALL be 0, sclk 1 and sync_n 1.

Reset
REQ-025 Reset SHALL asynchronously force state IDLE, sync_n=1, sclk=1, sdata=0, busy=0, done_tick=0, overrun=0, holding register empty and counters zero.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately; the sample SHALL be discarded and not resent.

Structure
REQ-027 Shared package filtro_pkg SHALL hold NF, MagnitudF, DecimalF, the frame width of 16, the DAC width of 12 and the state encoding.
REQ-028 The sclk timing SHALL live in sub-module generador_sclk, a DIV counter emitting rise and fall ticks with a clear input.

Verification
REQ-029 The bench SHALL check: Data_In=25'h0000000 with enable -> frame 0x0800 captured on sclk falling edges; done_tick after 32*DIV+2*DIV+1 cycles.
REQ-030 The bench SHALL check: Data_In=25'h0008000 (+0.5) -> 0x0C00; Data_In=25'h0010000 (+1.0) -> 0x0FFF (saturated).
REQ-031 The bench SHALL check: Data_In=25'h1FF0000 (-1.0) -> 0x0000; Data_In=25'h1F00000 (-16.0) -> 0x0000.
REQ-032 The bench SHALL check: enable with A, then B and C during A's frame -> overrun pulse on C; frames A then C back-to-back with a 2*DIV gap; B is never sent.
REQ-033 The bench SHALL check: Reset asserted at the 7th sclk edge -> sync_n=1 and sclk=1 in the same cycle, no done_tick, and the next enable starts a fresh frame.
REQ-034 The bench SHALL check: enable in the GAP cycle coinciding with the pending drain -> no overrun and three frames in order.
